lector_contador: RTL and testbench
==================================

# lector_contador

Requester-side controller for the per-FIFO pop counter block. When the datapath is in IDLE and a read is commanded, it walks `idx` 0 to 3, issues one `req` pulse per FIFO, and waits for `valid_contador`. It captures each 5-bit `contador_out` into a dedicated register. It then presents all four counts with a one-cycle `done` pulse. It sits between the top-level control/test logic and the counter block, on the opposite end of the `req`/`idx`/`valid_contador` handshake.

## Interface
Parameters:
- `DATA_WIDTH`, default 5: width of each count; matches `contador_out`.
- `TIMEOUT`, default 8: cycles to wait for `valid_contador` after a request. Legal range 1..15; timer is 4 bits.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  read command; sampled only in INACTIVO.
- `IDLE`  in  1  datapath idle indication; the counter answers only while high.
- `valid_contador`  in  1  counter response valid.
- `contador_out`  in  DATA_WIDTH  counter response data.
- `req`  out  1  request to counter, one-cycle pulse.
- `idx`  out  2  FIFO index being requested.
- `cuenta_F0` to `cuenta_F3`  out  DATA_WIDTH each  captured counts.
- `busy`  out  1  high in every state except INACTIVO.
- `done`  out  1  one-cycle pulse when all four counts are captured.
- `error`  out  1  sticky flag for a timeout or an IDLE drop.

## Operation
- Reset: state INACTIVO. `req`, `idx`, `cuenta_F0..F3`, `busy`, `done` and `error` are all 0.
- All outputs are registered. No combinational path runs from any input to any output.
- FSM states are INACTIVO, PEDIR, ESPERA and LISTO.
- INACTIVO:
  - If `start` and `IDLE` are both high: clear `cuenta_F0..F3` and `error`, set `idx`=0, go to PEDIR.
  - `start` with `IDLE`=0 is ignored and not remembered.
- PEDIR: `req`=1 for exactly this cycle with the current `idx`. Clear the timer and go to ESPERA. A `valid_contador` seen in this cycle is ignored.
- ESPERA: `req`=0.
  - On `valid_contador`=1: write `contador_out` into `cuenta_F[idx]`.
  - If the timer reaches TIMEOUT-1 with no valid: write 0 into `cuenta_F[idx]` and set `error`=1.
  - After either capture: if `idx`==3, go to LISTO; otherwise increment `idx` and go to PEDIR.
  - Otherwise increment the timer and stay in ESPERA.
- LISTO: `done`=1 for one cycle, then go to INACTIVO. `idx` holds 3 until the next accepted start.
- IDLE drop: `IDLE`=0 in PEDIR or ESPERA aborts the sequence.
  - Next state is INACTIVO, `error`=1, and `done` is never pulsed.
  - Counts already captured keep their values; counts not yet captured stay 0.
  - The abort has priority over a simultaneous `valid_contador`; the data is discarded.
- `start` while `busy`=1 is ignored.
- `valid_contador` in INACTIVO or LISTO is ignored.
- `reset` mid-sequence returns everything to reset values on the next edge, including `error`.
- Captured data is stored as-is; there is no arithmetic and no saturation.

## Timing
- Edge E0 samples `start`. Cycle 1 is PEDIR with `req`=1 and `idx`=0. Cycle 2 is ESPERA.
- With the counter answering one cycle after `req` (valid in the ESPERA cycle), each FIFO takes 2 cycles:
  - PEDIR at cycles 1, 3, 5 and 7, with `idx` 0, 1, 2 and 3.
  - `done`=1 in cycle 9.
  - `busy` is high in cycles 1 through 9.
  - `busy`=0 and a new start can be accepted in cycle 10.
- `cuenta_F[n]` becomes visible in the cycle after the ESPERA cycle that captured it.
- Worst case with every request timing out: `done` in cycle 1 + 4·(1+TIMEOUT) = 37 for TIMEOUT=8.
- `req` is never high in two consecutive cycles.

## Test plan
- Nominal read: reset for 3 cycles, then `IDLE`=1 and `start` pulse. The counter model returns 0, 1, 3, 1 one cycle after each `req`. Required: `req` at cycles 1/3/5/7 with `idx` 0/1/2/3; `cuenta_F0..F3`=0/1/3/1; `done` in cycle 9; `error`=0.
- Timeout: the model never answers for `idx`=2, and returns 8, 1, –, 1 otherwise. Required: `cuenta_F2`=0; `error`=1; `done` asserted, with ESPERA for `idx`=2 lasting 8 cycles.
- IDLE abort: drop `IDLE` during ESPERA of `idx`=1 while `valid_contador`=1 with data 7. Required: `cuenta_F1`=0 and `cuenta_F0` retained; `busy`=0 on the next cycle; `error`=1; no `done`.
- Ignored commands:
  - `start` with `IDLE`=0 gives no `req`.
  - `start` while busy has no effect on the sequence.
  - Spurious `valid_contador` in INACTIVO changes no count.
- Reset mid-operation: assert `reset` in ESPERA of `idx`=2. Required: next cycle shows all outputs 0 and state INACTIVO. A fresh start then completes normally with the 9-cycle latency.

Source files
------------

// File: rtl/lector_contador.sv
// Requester-side controller for the per-FIFO pop counter: walks idx 0..3,
// pulses req per FIFO, captures each returned count and reports with done.
module lector_contador #(
  parameter int DATA_WIDTH = 5,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  IDLE,
  input  logic                  valid_contador,
  input  logic [DATA_WIDTH-1:0] contador_out,
  output logic                  req,
  output logic [1:0]            idx,
  output logic [DATA_WIDTH-1:0] cuenta_F0,
  output logic [DATA_WIDTH-1:0] cuenta_F1,
  output logic [DATA_WIDTH-1:0] cuenta_F2,
  output logic [DATA_WIDTH-1:0] cuenta_F3,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    PEDIR    = 2'd1,
    ESPERA   = 2'd2,
    LISTO    = 2'd3
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_idx;
  logic [1:0]            w_idx_next;
  logic [3:0]            r_timer;
  logic [3:0]            w_timer_next;
  logic                  r_error;
  logic                  w_error_next;
  logic                  r_req;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_cuenta      [4];
  logic [DATA_WIDTH-1:0] w_cuenta_next [4];

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_timer_next = r_timer;
    w_error_next = r_error;
    for (int i = 0; i < 4; i++) begin
      w_cuenta_next[i] = r_cuenta[i];
    end

    unique case (r_state)
      INACTIVO: begin
        if (start && IDLE) begin
          for (int i = 0; i < 4; i++) begin
            w_cuenta_next[i] = '0;
          end
          w_error_next = 1'b0;
          w_idx_next   = 2'd0;
          w_state_next = PEDIR;
        end
      end

      PEDIR: begin
        if (!IDLE) begin
          w_error_next = 1'b1;
          w_state_next = INACTIVO;
        end else begin
          w_timer_next = 4'd0;
          w_state_next = ESPERA;
        end
      end

      ESPERA: begin
        // An IDLE drop wins over a response arriving in the same cycle.
        if (!IDLE) begin
          w_error_next = 1'b1;
          w_state_next = INACTIVO;
        end else if (valid_contador || (r_timer == TMO_LAST)) begin
          if (valid_contador) begin
            w_cuenta_next[r_idx] = contador_out;
          end else begin
            w_cuenta_next[r_idx] = '0;
            w_error_next         = 1'b1;
          end
          if (r_idx == 2'd3) begin
            w_state_next = LISTO;
          end else begin
            w_idx_next   = r_idx + 2'd1;
            w_state_next = PEDIR;
          end
        end else begin
          w_timer_next = r_timer + 4'd1;
        end
      end

      LISTO: begin
        w_state_next = INACTIVO;
      end

      default: begin
        w_state_next = INACTIVO;
      end
    endcase
  end

  // Output flags are computed from the next state so they appear registered
  // in the very cycle the FSM occupies that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INACTIVO;
      r_idx   <= 2'd0;
      r_timer <= 4'd0;
      r_error <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      // NOTE: the count registers are visible outputs that must read 0 out of
      // reset, so this small array is reset like any other register.
      for (int i = 0; i < 4; i++) begin
        r_cuenta[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every register take its new value
      // from the same pre-edge snapshot, independent of statement order.
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_timer <= w_timer_next;
      r_error <= w_error_next;
      r_req   <= (w_state_next == PEDIR);
      r_busy  <= (w_state_next != INACTIVO);
      r_done  <= (w_state_next == LISTO);
      for (int i = 0; i < 4; i++) begin
        r_cuenta[i] <= w_cuenta_next[i];
      end
    end
  end

  assign req       = r_req;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign cuenta_F0 = r_cuenta[0];
  assign cuenta_F1 = r_cuenta[1];
  assign cuenta_F2 = r_cuenta[2];
  assign cuenta_F3 = r_cuenta[3];

endmodule

// File: tb/tb_lector_contador.sv
// Directed bench for lector_contador: a per-cycle driver plays the counter
// side of the handshake and each scenario task checks its own results.
module tb_lector_contador;

  logic       clk;
  logic       reset;
  logic       start;
  logic       IDLE;
  logic       valid_contador;
  logic [4:0] contador_out;
  logic       req;
  logic [1:0] idx;
  logic [4:0] cuenta_F0;
  logic [4:0] cuenta_F1;
  logic [4:0] cuenta_F2;
  logic [4:0] cuenta_F3;
  logic       busy;
  logic       done;
  logic       error;

  int n_vec;
  int n_err;

  // Observations recorded by run_read
  int req_cyc [4];
  int req_idx [4];
  int n_req;
  int done_cyc;
  int n_done;
  int end_cyc;
  bit consec;

  lector_contador #(.DATA_WIDTH(5), .TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .IDLE           (IDLE),
    .valid_contador (valid_contador),
    .contador_out   (contador_out),
    .req            (req),
    .idx            (idx),
    .cuenta_F0      (cuenta_F0),
    .cuenta_F1      (cuenta_F1),
    .cuenta_F2      (cuenta_F2),
    .cuenta_F3      (cuenta_F3),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a read in the current cycle (cycle 0). Cycle c is the period after
  // edge Ec. The counter answers one cycle after req when answer[idx] is set.
  task automatic run_read(input logic [3:0][4:0] data, input logic [3:0] answer,
                          input int abort_c, input int reset_c, input bit start_busy);
    bit         pending;
    bit         fire;
    logic [1:0] pidx;
    bit         prev_req;
    pending  = 0;
    pidx     = 2'd0;
    prev_req = 0;
    n_req    = 0;
    n_done   = 0;
    done_cyc = -1;
    end_cyc  = -1;
    consec   = 0;
    for (int i = 0; i < 4; i++) begin
      req_cyc[i] = -1;
      req_idx[i] = -1;
    end
    start = 1'b1;
    IDLE  = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start          = start_busy && (c >= 2) && (c <= 9);
      IDLE           = (abort_c < 0) || (c < abort_c);
      reset          = (c == reset_c);
      fire           = pending;
      valid_contador = fire;
      contador_out   = fire ? data[pidx] : 5'd0;
      pending        = 0;
      if (req) begin
        if (n_req < 4) begin
          req_cyc[n_req] = c;
          req_idx[n_req] = int'(idx);
        end
        n_req++;
        pending = answer[idx];
        pidx    = idx;
        if (prev_req) consec = 1;
      end
      prev_req = req;
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (!busy) begin
        end_cyc = c;
        break;
      end
    end
    start          = 1'b0;
    valid_contador = 1'b0;
    contador_out   = 5'd0;
    reset          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    IDLE  = 1'b0;
    valid_contador = 1'b0;
    contador_out   = 5'd0;
    repeat (3) tick();
    n_vec++;
    if ({req, idx, cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, busy, done, error} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b idx=%0d F=%0d/%0d/%0d/%0d busy=%b done=%b error=%b, want all 0",
               req, idx, cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, busy, done, error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal(input string tag);
    run_read({5'd1, 5'd3, 5'd1, 5'd0}, 4'b1111, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (req_cyc[i] !== 2 * i + 1 || req_idx[i] !== i) begin
        n_err++;
        $display("FAIL %s_req%0d: got cycle %0d idx %0d, want cycle %0d idx %0d",
                 tag, i, req_cyc[i], req_idx[i], 2 * i + 1, i);
      end
    end
    n_vec++;
    if (done_cyc !== 9 || n_done !== 1 || end_cyc !== 10) begin
      n_err++;
      $display("FAIL %s_timing: got done cycle %0d (x%0d) idle cycle %0d, want 9 (x1) 10",
               tag, done_cyc, n_done, end_cyc);
    end
    n_vec++;
    if ({cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3} !== {5'd0, 5'd1, 5'd3, 5'd1} || error !== 1'b0) begin
      n_err++;
      $display("FAIL %s_counts: got %0d/%0d/%0d/%0d error=%b, want 0/1/3/1 error=0",
               tag, cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, error);
    end
    n_vec++;
    if (consec !== 1'b0 || n_req !== 4) begin
      n_err++;
      $display("FAIL %s_req_pulse: got consecutive=%b count=%0d, want 0 and 4", tag, consec, n_req);
    end
  endtask

  task automatic test_timeout();
    run_read({5'd1, 5'd0, 5'd1, 5'd8}, 4'b1011, -1, -1, 1'b0);
    n_vec++;
    if (req_cyc[2] !== 5 || req_cyc[3] - req_cyc[2] - 1 !== 8) begin
      n_err++;
      $display("FAIL timeout_wait: got idx2 req cycle %0d, espera %0d cycles, want 5 and 8",
               req_cyc[2], req_cyc[3] - req_cyc[2] - 1);
    end
    n_vec++;
    if (done_cyc !== 16 || n_done !== 1) begin
      n_err++;
      $display("FAIL timeout_done: got cycle %0d (x%0d), want 16 (x1)", done_cyc, n_done);
    end
    n_vec++;
    if ({cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3} !== {5'd8, 5'd1, 5'd0, 5'd1} || error !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_counts: got %0d/%0d/%0d/%0d error=%b, want 8/1/0/1 error=1",
               cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, error);
    end
  endtask

  task automatic test_start_while_busy();
    run_read({5'd8, 5'd6, 5'd4, 5'd2}, 4'b1111, -1, -1, 1'b1);
    n_vec++;
    if (req_cyc[3] !== 7 || n_req !== 4 || done_cyc !== 9 || end_cyc !== 10) begin
      n_err++;
      $display("FAIL busy_start_seq: got last req %0d reqs %0d done %0d idle %0d, want 7 4 9 10",
               req_cyc[3], n_req, done_cyc, end_cyc);
    end
    n_vec++;
    if ({cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3} !== {5'd2, 5'd4, 5'd6, 5'd8} || error !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_counts: got %0d/%0d/%0d/%0d error=%b, want 2/4/6/8 error=0",
               cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, error);
    end
    tick();
    n_vec++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_after: got req=%b busy=%b, want 0 0", req, busy);
    end
  endtask

  task automatic test_spurious_valid();
    valid_contador = 1'b1;
    contador_out   = 5'd31;
    repeat (3) tick();
    valid_contador = 1'b0;
    contador_out   = 5'd0;
    tick();
    n_vec++;
    if ({cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3} !== {5'd2, 5'd4, 5'd6, 5'd8} || busy !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_valid: got %0d/%0d/%0d/%0d busy=%b, want 2/4/6/8 busy=0",
               cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, busy);
    end
  endtask

  task automatic test_start_no_idle();
    int seen;
    seen  = 0;
    start = 1'b1;
    IDLE  = 1'b0;
    repeat (3) begin
      tick();
      if (req || busy) seen++;
    end
    start = 1'b0;
    IDLE  = 1'b1;
    repeat (2) begin
      tick();
      if (req || busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL start_no_idle: got %0d cycles with req/busy, want 0", seen);
    end
  endtask

  task automatic test_idle_abort();
    run_read({5'd1, 5'd1, 5'd7, 5'd5}, 4'b1111, 4, -1, 1'b0);
    n_vec++;
    if (end_cyc !== 5 || n_done !== 0) begin
      n_err++;
      $display("FAIL abort_timing: got idle cycle %0d done pulses %0d, want 5 and 0", end_cyc, n_done);
    end
    n_vec++;
    if ({cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3} !== {5'd5, 5'd0, 5'd0, 5'd0} || error !== 1'b1) begin
      n_err++;
      $display("FAIL abort_counts: got %0d/%0d/%0d/%0d error=%b, want 5/0/0/0 error=1",
               cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, error);
    end
    IDLE = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    run_read({5'd3, 5'd2, 5'd9, 5'd5}, 4'b1110, -1, 13, 1'b0);
    n_vec++;
    if (end_cyc !== 14 || req_cyc[2] !== 12) begin
      n_err++;
      $display("FAIL reset_mid_timing: got idle cycle %0d idx2 req %0d, want 14 and 12", end_cyc, req_cyc[2]);
    end
    n_vec++;
    if ({req, idx, cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, busy, done, error} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got req=%b idx=%0d F=%0d/%0d/%0d/%0d busy=%b done=%b error=%b, want all 0",
               req, idx, cuenta_F0, cuenta_F1, cuenta_F2, cuenta_F3, busy, done, error);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_nominal("nominal");
    test_timeout();
    test_start_while_busy();
    test_spurious_valid();
    test_start_no_idle();
    test_idle_abort();
    test_reset_mid();
    test_nominal("after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
